instr_fetch: RTL and testbench

Instruction fetch initiator that drives the read side of `instr_mem` and delivers instructions to decode. It holds the fetch PC, issues one word read per cycle while `mem_done` is high and buffer space exists, and captures each response the following cycle into a small FIFO. The FIFO feeds a valid/ready port toward decode. Branch or jump redirects from execute flush all buffered and in-flight words.

---
 rtl/instr_fetch.sv | 146 ++++++++++++++
 tb/tb_instr_fetch.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch: drives instr_mem reads, buffers {pc, word} responses in a small FIFO and
// hands them to decode over valid/ready. A redirect flushes buffered and in-flight words.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] mem_adr,
    output logic        mem_load,
    output logic [31:0] mem_in,
    input  logic [31:0] mem_out,
    input  logic        mem_done,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        ins_valid,
    output logic [31:0] ins,
    output logic [31:0] ins_pc,
    input  logic        ins_ready
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [0:0] {StBoot, StRun} state_e;

    state_e        st_q, st_d;
    logic          run;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic          inflight_q, inflight_d;
    logic [31:0]   inflight_pc_q, inflight_pc_d;
    logic [31:0]   fifo_word_q [DEPTH];
    logic [31:0]   fifo_pc_q   [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d, occ_after, rem;
    logic [31:0]   head_word_q, head_word_d, head_pc_q, head_pc_d;
    logic          pop, push, issue;
    logic          unused_redirect_lsb;

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) st_q <= StBoot;
        else        st_q <= st_d;
    end

    // FSM: next state
    always_comb begin
        st_d = st_q;
        unique case (st_q)
            StBoot:  st_d = StRun;
            StRun:   st_d = StRun;
            default: st_d = StBoot;
        endcase
    end

    // FSM: outputs
    always_comb begin
        run = (st_q == StRun);
    end

    assign ins_valid = (count_q != '0);
    assign pop       = ins_valid && ins_ready;
    assign push      = inflight_q && !redirect;
    // Occupancy once this cycle's pop retires, counting the word still in flight.
    assign occ_after = count_q + CW'(inflight_q) - CW'(pop);
    assign rem       = count_q - CW'(pop);
    assign issue     = run && mem_done && !redirect && (occ_after < CW'(DEPTH));

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = issue;
        inflight_pc_d = inflight_pc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        head_word_d   = head_word_q;
        head_pc_d     = head_pc_q;
        if (redirect) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (issue) begin
                fetch_pc_d    = fetch_pc_q + 32'd4;
                inflight_pc_d = fetch_pc_q;
            end
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
            // Head registers mirror the next FIFO head; they hold when the FIFO drains.
            if (rem == '0) begin
                if (push) begin
                    head_word_d = mem_out;
                    head_pc_d   = inflight_pc_q;
                end
            end else begin
                head_word_d = fifo_word_q[rd_ptr_d];
                head_pc_d   = fifo_pc_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            head_word_q   <= '0;
            head_pc_q     <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                fifo_word_q[i] <= '0;
                fifo_pc_q[i]   <= '0;
            end
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            head_word_q   <= head_word_d;
            head_pc_q     <= head_pc_d;
            if (push) begin
                fifo_word_q[wr_ptr_q] <= mem_out;
                fifo_pc_q[wr_ptr_q]   <= inflight_pc_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push && !pop) begin
            assert (count_q < CW'(DEPTH)) else $error("instr_fetch: push into full buffer");
        end
    end

    assign mem_adr             = fetch_pc_q;
    assign mem_load            = 1'b0;
    assign mem_in              = 32'h0;
    assign ins                 = head_word_q;
    assign ins_pc              = head_pc_q;
    assign unused_redirect_lsb = ^redirect_pc[1:0];

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: boot stream, backpressure, redirects, mem_done stall,
// async reset, plus a second instance booting at 32'hFFFFFFFC to show PC wrap.
module tb_instr_fetch;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] mem_adr, mem_in, mem_out, redirect_pc, ins, ins_pc;
    logic        mem_load, mem_done, redirect, ins_valid, ins_ready;

    logic [31:0] w_mem_adr, w_mem_in, w_mem_out, w_redirect_pc, w_ins, w_ins_pc;
    logic        w_mem_load, w_mem_done, w_redirect, w_ins_valid, w_ins_ready;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // instr_mem stand-in: word k holds 32'h1000 + k, one-cycle read latency.
    always @(posedge clk) begin
        mem_out   <= 32'h1000 + {2'b00, mem_adr[31:2]};
        w_mem_out <= 32'h1000 + {2'b00, w_mem_adr[31:2]};
    end

    instr_fetch #(.RESET_PC(32'h0), .DEPTH(2)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_adr     (mem_adr),
        .mem_load    (mem_load),
        .mem_in      (mem_in),
        .mem_out     (mem_out),
        .mem_done    (mem_done),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .ins_valid   (ins_valid),
        .ins         (ins),
        .ins_pc      (ins_pc),
        .ins_ready   (ins_ready)
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFFC), .DEPTH(2)) u_wrap (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_adr     (w_mem_adr),
        .mem_load    (w_mem_load),
        .mem_in      (w_mem_in),
        .mem_out     (w_mem_out),
        .mem_done    (w_mem_done),
        .redirect    (w_redirect),
        .redirect_pc (w_redirect_pc),
        .ins_valid   (w_ins_valid),
        .ins         (w_ins),
        .ins_pc      (w_ins_pc),
        .ins_ready   (w_ins_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Entered one step after the edge at which rst_n was released; ends with head pc 12.
    task automatic check_boot(input bit with_wrap);
        tick();
        chk("boot_e0_valid", {31'b0, ins_valid}, 32'h0);
        chk("boot_e0_adr", mem_adr, 32'h0);
        tick();
        chk("boot_e1_valid", {31'b0, ins_valid}, 32'h0);
        chk("boot_e1_adr", mem_adr, 32'h4);
        if (with_wrap) begin
            chk("wrap_stall_adr", w_mem_adr, 32'hFFFF_FFFC);
            w_mem_done = 1'b1;
        end
        tick();
        if (with_wrap) begin
            chk("wrap_adr_wrapped", w_mem_adr, 32'h0);
            chk("wrap_valid0", {31'b0, w_ins_valid}, 32'h0);
        end
        for (int k = 0; k < 4; k++) begin
            if (k > 0) tick();
            chk("boot_valid", {31'b0, ins_valid}, 32'h1);
            chk("boot_ins", ins, 32'h1000 + k);
            chk("boot_pc", ins_pc, 32'(4 * k));
            if (with_wrap && k == 1) begin
                chk("wrap_pc_top", w_ins_pc, 32'hFFFF_FFFC);
                chk("wrap_ins_top", w_ins, 32'h4000_0FFF);
            end
            if (with_wrap && k == 2) begin
                chk("wrap_pc_zero", w_ins_pc, 32'h0);
                chk("wrap_ins_zero", w_ins, 32'h1000);
            end
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        mem_done      = 1'b1;
        ins_ready     = 1'b1;
        redirect      = 1'b0;
        redirect_pc   = 32'h0;
        w_mem_done    = 1'b0;
        w_ins_ready   = 1'b1;
        w_redirect    = 1'b0;
        w_redirect_pc = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {31'b0, ins_valid}, 32'h0);
        chk("rst_ins", ins, 32'h0);
        chk("rst_pc", ins_pc, 32'h0);
        chk("rst_adr", mem_adr, 32'h0);
        chk("rst_load", {31'b0, mem_load}, 32'h0);
        chk("rst_mem_in", mem_in, 32'h0);
        chk("rst_wrap_adr", w_mem_adr, 32'hFFFF_FFFC);
        rst_n = 1'b1;
        check_boot(1'b1);

        // Backpressure: head pc 12 held, one more word buffered, issue stops at pc 20.
        ins_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("bp_valid", {31'b0, ins_valid}, 32'h1);
            chk("bp_ins", ins, 32'h1003);
            chk("bp_pc", ins_pc, 32'hC);
            chk("bp_adr", mem_adr, 32'h14);
        end
        ins_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rel_valid", {31'b0, ins_valid}, 32'h1);
            chk("rel_pc", ins_pc, 32'(16 + 4 * k));
            chk("rel_ins", ins, 32'h1000 + 32'(4 + k));
        end
        chk("rel_adr", mem_adr, 32'h24);

        // Redirect while pc 32 is in flight; that word must never show up.
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        tick();
        redirect = 1'b0;
        chk("rd_valid", {31'b0, ins_valid}, 32'h0);
        chk("rd_adr", mem_adr, 32'h40);
        chk("rd_pc_hold", ins_pc, 32'h1C);
        chk("rd_ins_hold", ins, 32'h1007);
        tick();
        chk("rd_stale_valid", {31'b0, ins_valid}, 32'h0);
        chk("rd_adr_next", mem_adr, 32'h44);
        tick();
        chk("rd_new_valid", {31'b0, ins_valid}, 32'h1);
        chk("rd_new_pc", ins_pc, 32'h40);
        chk("rd_new_ins", ins, 32'h1010);
        tick();
        chk("rd_seq_pc", ins_pc, 32'h44);
        chk("rd_seq_ins", ins, 32'h1011);

        // Misaligned redirect target.
        redirect    = 1'b1;
        redirect_pc = 32'h43;
        tick();
        redirect = 1'b0;
        chk("mis_adr", mem_adr, 32'h40);
        chk("mis_valid", {31'b0, ins_valid}, 32'h0);
        tick();
        tick();
        chk("mis_pc", ins_pc, 32'h40);
        chk("mis_ins", ins, 32'h1010);
        tick();
        chk("mis_seq_pc", ins_pc, 32'h44);

        // mem_done stall: in-flight pc 0x48 still lands, nothing new issues.
        mem_done = 1'b0;
        tick();
        chk("st_valid", {31'b0, ins_valid}, 32'h1);
        chk("st_pc", ins_pc, 32'h48);
        chk("st_adr1", mem_adr, 32'h4C);
        tick();
        chk("st_drained", {31'b0, ins_valid}, 32'h0);
        chk("st_pc_hold", ins_pc, 32'h48);
        chk("st_adr2", mem_adr, 32'h4C);
        tick();
        chk("st_empty", {31'b0, ins_valid}, 32'h0);
        chk("st_adr3", mem_adr, 32'h4C);
        mem_done = 1'b1;
        tick();
        chk("st_issue_valid", {31'b0, ins_valid}, 32'h0);
        chk("st_issue_adr", mem_adr, 32'h50);
        tick();
        chk("st_res_valid", {31'b0, ins_valid}, 32'h1);
        chk("st_res_pc", ins_pc, 32'h4C);
        chk("st_res_ins", ins, 32'h1013);

        // Fill to two entries, then reset between edges.
        ins_ready = 1'b0;
        tick();
        chk("ar_full_pc", ins_pc, 32'h4C);
        chk("ar_full_adr", mem_adr, 32'h54);
        #3;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", {31'b0, ins_valid}, 32'h0);
        chk("ar_adr", mem_adr, 32'h0);
        chk("ar_ins", ins, 32'h0);
        chk("ar_pc", ins_pc, 32'h0);
        ins_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        check_boot(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
